// File: rtl/hs_sync_arbiter_pkg.sv
// Shared types and helpers for the round-robin req/ack crossing scheduler.
// State encoding is fixed so that debug probes and checkers can decode it.
package hs_sync_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DROP = 2'd2
   } state_t;

   localparam int unsigned MAX_REQ = 16;

   // Round-robin candidate index: (base + offset) wrapped into [0, n).
   // Both operands are below n, so a single conditional subtract suffices.
   function automatic int unsigned rr_index(input int unsigned base,
                                            input int unsigned offset,
                                            input int unsigned n);
      int unsigned sum;
      sum = base + offset;
      if (sum >= n) begin
         sum = sum - n;
      end
      return sum;
   endfunction

endpackage

// File: rtl/hs_sync_arbiter_sync.sv
// Plain flop-chain synchronizer for a single asynchronous level.
// All stages clear on the asynchronous active-low reset.
module m_ff_sync #(
   parameter int NUM_FF = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [NUM_FF-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[NUM_FF-2:0], d};
      end
   end

   assign q = sync_q[NUM_FF-1];

endmodule

// File: rtl/hs_sync_arbiter.sv
// Source-domain scheduler: round-robin picks one requester, captures its word,
// then runs one 4-phase req/ack crossing (req up, ack up, req down, ack down).
module hs_sync_arbiter
   import hs_sync_arbiter_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   parameter  int DWIDTH  = 32,
   parameter  int SYNC_FF = 2,
   localparam int IDW     = $clog2(NUM_REQ)
) (
   input  logic                      i_src_clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        i_req_valid,
   input  logic [NUM_REQ*DWIDTH-1:0] i_req_data,
   output logic [NUM_REQ-1:0]        o_req_ready,
   output logic                      o_xfer_req,
   output logic [DWIDTH-1:0]         o_xfer_data,
   output logic [IDW-1:0]            o_xfer_id,
   input  logic                      i_xfer_ack,
   output logic                      o_busy,
   output logic                      o_done
);

   // Handshake: requester k holds i_req_valid[k] until o_req_ready[k]; the word
   // is taken at the clock edge ending the cycle where both are high.

   state_t             state_q;
   state_t             state_d;
   logic               ack_s;
   logic [IDW-1:0]     ptr_q;
   logic [IDW-1:0]     ptr_d;
   logic               grant_found;
   logic [IDW-1:0]     grant_idx;
   logic               grant_take;
   logic               req_q;
   logic [DWIDTH-1:0]  data_q;
   logic [IDW-1:0]     id_q;
   logic               done_q;

   m_ff_sync #(
      .NUM_FF (SYNC_FF)
   ) u_ack_sync (
      .clk   (i_src_clk),
      .rst_n (rst_n),
      .d     (i_xfer_ack),
      .q     (ack_s)
   );

   // First valid requester found scanning upward from ptr_q with wrap.
   always_comb begin
      int unsigned    cand;
      logic [IDW-1:0] cand_idx;
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      cand_idx    = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand     = rr_index(32'(ptr_q), i, NUM_REQ);
         cand_idx = IDW'(cand);
         if (!grant_found && i_req_valid[cand_idx]) begin
            grant_found = 1'b1;
            grant_idx   = cand_idx;
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (grant_idx == IDW'(NUM_REQ - 1)) begin
         ptr_d = '0;
      end else begin
         ptr_d = grant_idx + IDW'(1);
      end
   end

   // Grants are gated by rst_n so the combinational ready stays low in reset.
   always_comb begin
      state_d     = state_q;
      o_req_ready = '0;
      grant_take  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (rst_n && !ack_s && grant_found) begin
               grant_take             = 1'b1;
               o_req_ready[grant_idx] = 1'b1;
               state_d                = ST_REQ;
            end
         end
         ST_REQ: begin
            if (ack_s) begin
               state_d = ST_DROP;
            end
         end
         ST_DROP: begin
            if (!ack_s) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_src_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         req_q   <= 1'b0;
         data_q  <= '0;
         id_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= (state_d == ST_REQ);
         done_q  <= (state_q == ST_DROP) && (state_d == ST_IDLE);
         if (grant_take) begin
            data_q <= i_req_data[grant_idx*DWIDTH +: DWIDTH];
            id_q   <= grant_idx;
            ptr_q  <= ptr_d;
         end
      end
   end

   assign o_xfer_req  = req_q;
   assign o_xfer_data = data_q;
   assign o_xfer_id   = id_q;
   assign o_busy      = (state_q != ST_IDLE);
   assign o_done      = done_q;

   a_ready_onehot0 : assert property (@(posedge i_src_clk) disable iff (!rst_n)
      $onehot0(o_req_ready));

endmodule

// File: tb/tb_hs_sync_arbiter.sv
// Directed bench for hs_sync_arbiter: loopback and hand-driven acknowledge,
// grant order, stale-ack blocking, reset mid-transfer and slow destination.
module tb_hs_sync_arbiter;

   localparam int NUM_REQ = 4;
   localparam int DWIDTH  = 32;
   localparam int IDW     = 2;

   logic                      i_src_clk;
   logic                      rst_n;
   logic [NUM_REQ-1:0]        valid;
   logic [NUM_REQ*DWIDTH-1:0] data;
   logic [NUM_REQ-1:0]        o_req_ready;
   logic                      o_xfer_req;
   logic [DWIDTH-1:0]         o_xfer_data;
   logic [IDW-1:0]            o_xfer_id;
   logic                      i_xfer_ack;
   logic                      o_busy;
   logic                      o_done;
   logic                      loopback;
   logic                      ack_drv;

   int n_tests = 0;
   int n_fail  = 0;
   logic [NUM_REQ-1:0] exp_q[$];

   assign i_xfer_ack = loopback ? o_xfer_req : ack_drv;

   hs_sync_arbiter #(
      .NUM_REQ (NUM_REQ),
      .DWIDTH  (DWIDTH),
      .SYNC_FF (2)
   ) dut (
      .i_src_clk   (i_src_clk),
      .rst_n       (rst_n),
      .i_req_valid (valid),
      .i_req_data  (data),
      .o_req_ready (o_req_ready),
      .o_xfer_req  (o_xfer_req),
      .o_xfer_data (o_xfer_data),
      .o_xfer_id   (o_xfer_id),
      .i_xfer_ack  (i_xfer_ack),
      .o_busy      (o_busy),
      .o_done      (o_done)
   );

   // Clock / reset
   initial begin
      i_src_clk = 1'b0;
      forever #5 i_src_clk = ~i_src_clk;
   end

   initial begin
      #100us;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // Driver / checker tasks
   task automatic tick();
      @(posedge i_src_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_done(input string tag, input int max_cyc);
      int cyc;
      cyc = 0;
      while (o_done !== 1'b1 && cyc < max_cyc) begin
         tick();
         cyc++;
      end
      check({tag, "_done"}, 64'(o_done), 64'd1);
   endtask

   // Grant from IDLE with loopback ack, then follow it to o_done.
   task automatic do_xfer(input string tag, input logic [3:0] vmask, input logic [3:0] exp_rdy);
      int k;
      k = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (exp_rdy[i]) k = i;
      end
      valid = vmask;
      #1;
      check({tag, "_ready"}, 64'(o_req_ready), 64'(exp_rdy));
      tick();
      valid = '0;
      check({tag, "_id"}, 64'(o_xfer_id), 64'(k));
      check({tag, "_data"}, 64'(o_xfer_data), 64'(data[k*DWIDTH +: DWIDTH]));
      check({tag, "_req"}, 64'(o_xfer_req), 64'd1);
      wait_done(tag, 20);
   endtask

   initial begin
      int last;
      int grants;
      logic [3:0] e;

      rst_n    = 1'b0;
      valid    = 4'b0001;
      loopback = 1'b1;
      ack_drv  = 1'b0;
      data     = {32'hC0DE_0003, 32'hA5A5_0001, 32'hC0DE_0001, 32'hC0DE_0000};

      // Reset values, ready held low in reset even with a valid present
      tick();
      tick();
      check("rst_ready_in_reset", 64'(o_req_ready), 64'd0);
      valid = '0;
      rst_n = 1'b1;
      tick();
      check("rst_xfer_req", 64'(o_xfer_req), 64'd0);
      check("rst_xfer_data", 64'(o_xfer_data), 64'd0);
      check("rst_xfer_id", 64'(o_xfer_id), 64'd0);
      check("rst_busy", 64'(o_busy), 64'd0);
      check("rst_done", 64'(o_done), 64'd0);
      check("rst_ready", 64'(o_req_ready), 64'd0);

      // Single requester with loopback: cycle-exact timeline
      valid = 4'b0100;
      #1;
      check("t1_ready_c0", 64'(o_req_ready), 64'h4);
      tick();
      valid = '0;
      check("t1_req_c1", 64'(o_xfer_req), 64'd1);
      check("t1_data", 64'(o_xfer_data), 64'hA5A5_0001);
      check("t1_id", 64'(o_xfer_id), 64'd2);
      check("t1_busy_c1", 64'(o_busy), 64'd1);
      tick();
      tick();
      check("t1_req_c3", 64'(o_xfer_req), 64'd1);
      tick();
      check("t1_req_c4", 64'(o_xfer_req), 64'd0);
      tick();
      tick();
      check("t1_done_c6", 64'(o_done), 64'd0);
      tick();
      check("t1_done_c7", 64'(o_done), 64'd1);
      check("t1_id_c7", 64'(o_xfer_id), 64'd2);
      check("t1_busy_c7", 64'(o_busy), 64'd0);

      // All four valid from reset: order 0,1,2,3,0 every 7 cycles
      rst_n = 1'b0;
      tick();
      valid = 4'b1111;
      rst_n = 1'b1;
      exp_q = {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      last   = -1;
      grants = 0;
      for (int c = 0; c < 60 && grants < 5; c++) begin
         if (c > 0) tick();
         else #1;
         if (o_req_ready != '0) begin
            check("t2_onehot", 64'($onehot(o_req_ready)), 64'd1);
            e = exp_q.pop_front();
            check("t2_order", 64'(o_req_ready), 64'(e));
            if (last >= 0) begin
               check("t2_period", 64'(c - last), 64'd7);
               check("t2_done_with_grant", 64'(o_done), 64'd1);
            end
            last = c;
            grants++;
         end
      end
      check("t2_grant_count", 64'(grants), 64'd5);
      tick();
      valid = '0;
      check("t2_last_id", 64'(o_xfer_id), 64'd0);
      check("t2_last_data", 64'(o_xfer_data), 64'hC0DE_0000);
      wait_done("t2", 20);

      // Wrap: ptr=1 -> grant 2 (ptr 3) -> only 1 valid wraps (ptr 2) -> 2 beats 1
      do_xfer("t3_a", 4'b0100, 4'b0100);
      do_xfer("t3_wrap", 4'b0010, 4'b0010);
      do_xfer("t3_ptr2", 4'b0110, 4'b0100);

      // Stale ack blocks grants until the synchronized ack falls
      loopback = 1'b0;
      ack_drv  = 1'b1;
      tick();
      tick();
      valid = 4'b0001;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t4_blocked", 64'(o_req_ready), 64'd0);
      end
      ack_drv = 1'b0;
      tick();
      check("t4_sync_lag", 64'(o_req_ready), 64'd0);
      tick();
      check("t4_release", 64'(o_req_ready), 64'h1);
      loopback = 1'b1;
      tick();
      valid = '0;
      check("t4_id", 64'(o_xfer_id), 64'd0);
      wait_done("t4", 20);

      // Reset while in REQ
      loopback = 1'b0;
      ack_drv  = 1'b0;
      valid    = 4'b0010;
      #1;
      check("t5_ready", 64'(o_req_ready), 64'h2);
      tick();
      valid = '0;
      tick();
      check("t5_req_before", 64'(o_xfer_req), 64'd1);
      rst_n = 1'b0;
      valid = 4'b1001;
      #1;
      check("t5_req", 64'(o_xfer_req), 64'd0);
      check("t5_data", 64'(o_xfer_data), 64'd0);
      check("t5_id", 64'(o_xfer_id), 64'd0);
      check("t5_busy", 64'(o_busy), 64'd0);
      check("t5_done", 64'(o_done), 64'd0);
      check("t5_ready_rst", 64'(o_req_ready), 64'd0);
      tick();
      rst_n = 1'b1;
      #1;
      check("t5_ptr0_wins", 64'(o_req_ready), 64'h1);
      tick();
      valid    = '0;
      loopback = 1'b1;
      check("t5_id_after", 64'(o_xfer_id), 64'd0);
      wait_done("t5", 20);

      // Slow destination: ack 20 cycles after req
      loopback = 1'b0;
      ack_drv  = 1'b0;
      valid    = 4'b1000;
      #1;
      check("t6_ready", 64'(o_req_ready), 64'h8);
      tick();
      valid = '0;
      for (int i = 0; i < 20; i++) begin
         check("t6_req_hold", 64'(o_xfer_req), 64'd1);
         check("t6_data_hold", 64'(o_xfer_data), 64'hC0DE_0003);
         check("t6_busy", 64'(o_busy), 64'd1);
         tick();
      end
      ack_drv = 1'b1;
      tick();
      tick();
      check("t6_req_ack_s", 64'(o_xfer_req), 64'd1);
      tick();
      check("t6_req_fall", 64'(o_xfer_req), 64'd0);
      check("t6_busy_drop", 64'(o_busy), 64'd1);
      ack_drv = 1'b0;
      tick();
      tick();
      check("t6_done_early", 64'(o_done), 64'd0);
      tick();
      check("t6_done", 64'(o_done), 64'd1);
      check("t6_id", 64'(o_xfer_id), 64'd3);
      check("t6_data_end", 64'(o_xfer_data), 64'hC0DE_0003);
      tick();
      check("t6_done_pulse", 64'(o_done), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
